uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1, meaning clk cycles per oversample tick (range 1..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (range 5..8).
REQ-003 SHALL have parameter PARITY_ODD, default 0, meaning odd parity when 1 and even parity when 0 (used only with UART_RX_PARITY_EN).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port data_out, output, DATA_BITS bits: last received payload, LSB-first assembled.
REQ-008 SHALL have port data_valid, output, 1 bit: one-cycle pulse, good frame in data_out.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-010 SHALL have port parity_err, output, 1 bit: one-cycle pulse, parity mismatch (tied 0 without macro).
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-013 SHALL generate a tick every CLK_DIV clk cycles, with 16 ticks per bit; the tick counter restarts on start detection.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-015 IDLE: on a synchronized high-to-low transition, SHALL go to START with tick count 0.
REQ-016 START: at tick 7, a line still high SHALL count as a false start and return to IDLE with no output pulse; otherwise SHALL continue to DATA with bit counter 0.
REQ-017 DATA: each bit SHALL be the 2-of-3 majority of samples at ticks 7, 8 and 9, shifted in LSB first; after DATA_BITS bits, SHALL go to PARITY with the macro, else to STOP.
REQ-018 PARITY: SHALL take a majority sample and compare it against the XOR of the payload (inverted when PARITY_ODD=1).
REQ-019 STOP: SHALL take a majority sample at tick 9 and load data_out in the following cycle.
REQ-020 A high stop bit with no parity error SHALL pulse data_valid for exactly 1 cycle, coincident with the data_out update, then go to IDLE.
REQ-021 A low stop bit SHALL pulse frame_err, update data_out, suppress data_valid, and go to WAIT_IDLE.
REQ-022 WAIT_IDLE SHALL return to IDLE only after the line is sampled high, so a break condition never yields repeated frames.
REQ-023 A parity error with a good stop bit SHALL pulse parity_err, update data_out, and suppress data_valid.
REQ-024 If both errors occur in one frame, both error pulses SHALL assert in the same cycle.
REQ-025 data_out SHALL hold its value between frames.
REQ-026 A new start edge SHALL be accepted from the first IDLE cycle after STOP, so back-to-back frames need no gap.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, all counters to 0, data_out to 0, data_valid, frame_err, parity_err and busy to 0, and both synchronizer flops to 1.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame without emitting a pulse.
REQ-029 After reset release, reception SHALL begin only on a fresh falling edge.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined SHALL insert the PARITY state and a parity bit after the payload, and drive parity_err.
REQ-031 Without UART_RX_PARITY_EN, the frame SHALL be start, DATA_BITS payload bits and stop; parity_err SHALL be constant 0 and PARITY unreachable.

Structure
REQ-032 Package uart_pkg SHALL hold the state enum typedef, the OVERSAMPLE=16 constant and the sample-tick constants 7, 8, 9 and the stop sample tick; the future transmitter shares this package.
REQ-033 Sub-module uart_baud_tick SHALL implement the CLK_DIV divider with a synchronous restart input and a tick output.

Verification
REQ-034 Scenario, clean frame: CLK_DIV=1, no parity, frame 0x55 -> data_valid high 1 cycle, data_out=0x55, busy low afterwards, no error pulse.
REQ-035 Scenario, glitch: rxd low for 4 ticks then high -> no pulse on any output, state back in IDLE, busy low.
REQ-036 Scenario, framing error: frame 0xA3 with stop bit low, then line held low for 3 bit times -> one frame_err pulse, data_out=0xA3, no data_valid, and no second frame until rxd returns high.
REQ-037 Scenario, parity: macro on, PARITY_ODD=0, 0x07 with parity bit 1 -> data_valid; same byte with parity bit 0 -> parity_err, no data_valid.
REQ-038 Scenario, reset mid-frame: rst_n pulsed low during data bit 4 of 0xFF -> all outputs 0 immediately; next frame 0x3C -> data_valid, data_out=0x3C.
REQ-039 Scenario, back-to-back: 0x00 then 0xFF with zero idle gap, and with a ±3% bit-period skew applied to the sender -> two data_valid pulses with data_out 0x00 then 0xFF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling and sample-point constants.
// Intended for reuse by both the receiver and the future transmitter.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

    localparam logic [TICK_W-1:0] SAMPLE_TICK_A    = TICK_W'(7);
    localparam logic [TICK_W-1:0] SAMPLE_TICK_B    = TICK_W'(8);
    localparam logic [TICK_W-1:0] SAMPLE_TICK_C    = TICK_W'(9);
    localparam logic [TICK_W-1:0] STOP_SAMPLE_TICK = TICK_W'(9);
    localparam logic [TICK_W-1:0] LAST_TICK        = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Clock cycles lost between a line edge and the first tick are 3; express them in ticks (rounded up).
    function automatic int start_latency_ticks(input int clk_div);
        return (3 + clk_div - 1) / clk_div;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every CLK_DIV clocks, phase reset by 'restart'.
module uart_baud_tick #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam logic [15:0] LAST_COUNT = 16'(CLK_DIV - 1);

    logic [15:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (restart || (count == LAST_COUNT)) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    assign tick = !restart && (count == LAST_COUNT);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled with 2-of-3 majority voting per bit.
// Define UART_RX_PARITY_EN to add a parity bit after the payload and drive parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 1,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    // START is shortened by the synchronizer/edge-detect delay so later sample points sit near bit centres.
    localparam int START_TRIM = start_latency_ticks(CLK_DIV);
    localparam logic [TICK_W-1:0] START_LAST_TICK = TICK_W'(OVERSAMPLE - 1 - START_TRIM);

    uart_state_t state;
    uart_state_t next_state;

    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic [1:0]           sync_fill;
    logic                 armed;
    logic                 start_edge;
    logic                 tick;
    logic [TICK_W-1:0]    tick_cnt;
    logic [2:0]           bit_cnt;
    logic [1:0]           sample_hist;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 sample_maj;
    logic                 sample_now;
    logic                 bit_end;
    logic                 stop_sample;
    logic                 parity_bad;
    logic                 load_data;
    logic                 valid_set;
    logic                 ferr_set;

    // Edges are only trusted once the synchronizer holds real samples and the line has been seen idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            rx_meta   <= rxd;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rx_sync) begin
                armed <= 1'b1;
            end
        end
    end

    assign start_edge = (state == IDLE) && armed && rx_prev && !rx_sync;

    uart_baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_baud_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(start_edge),
        .tick   (tick)
    );

    assign sample_maj  = majority3(sample_hist[0], sample_hist[1], rx_sync);
    assign sample_now  = tick && (tick_cnt == SAMPLE_TICK_C);
    assign bit_end     = tick && (tick_cnt == LAST_TICK);
    assign stop_sample = (state == STOP) && tick && (tick_cnt == STOP_SAMPLE_TICK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    next_state = START;
                end
            end
            START: begin
                if (tick && (tick_cnt == SAMPLE_TICK_A) && rx_sync) begin
                    next_state = IDLE;
                end else if (tick && (tick_cnt == START_LAST_TICK)) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (bit_end) begin
                    next_state = STOP;
                end
`else
                next_state = IDLE;
`endif
            end
            STOP: begin
                if (stop_sample) begin
                    next_state = sample_maj ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_sync) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        load_data = 1'b0;
        valid_set = 1'b0;
        ferr_set  = 1'b0;
        if (stop_sample) begin
            load_data = 1'b1;
            ferr_set  = !sample_maj;
            valid_set = sample_maj && !parity_bad;
        end
    end

    // Tick phase restarts at the start edge and again at the end of the shortened start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            sample_hist <= '0;
            shift_reg   <= '0;
        end else begin
            if (start_edge) begin
                tick_cnt <= '0;
            end else if (tick) begin
                if ((state == START) && (tick_cnt == START_LAST_TICK)) begin
                    tick_cnt <= '0;
                end else begin
                    tick_cnt <= tick_cnt + TICK_W'(1);
                end
            end
            if (state == START) begin
                bit_cnt <= '0;
            end else if ((state == DATA) && bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (tick && (tick_cnt == SAMPLE_TICK_A)) begin
                sample_hist[0] <= rx_sync;
            end
            if (tick && (tick_cnt == SAMPLE_TICK_B)) begin
                sample_hist[1] <= rx_sync;
            end
            if ((state == DATA) && sample_now) begin
                shift_reg <= {sample_maj, shift_reg[DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (load_data) begin
                data_out <= shift_reg;
            end
            data_valid <= valid_set;
            frame_err  <= ferr_set;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bit;
    logic perr_q;

    assign parity_bad = parity_bit ^ (^shift_reg) ^ (PARITY_ODD != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_bit <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            if ((state == PARITY) && sample_now) begin
                parity_bit <= sample_maj;
            end
            perr_q <= stop_sample && parity_bad;
        end
    end

    assign parity_err = perr_q;
`else
    logic unused_parity_odd;

    assign unused_parity_odd = (PARITY_ODD != 0);
    assign parity_bad        = 1'b0;
    assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed scoreboard bench for uart_rx (CLK_DIV=1, 8 data bits); parity steps run when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int CLK_HALF = 50;
    localparam int BIT_T    = 1600;
    localparam int BIT_FAST = 1552;
    localparam int BIT_SLOW = 1648;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_ENABLED = 1'b1;
`else
    localparam bit PARITY_ENABLED = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       dv;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       rxd   = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    uart_rx #(
        .CLK_DIV   (1),
        .DATA_BITS (8),
        .PARITY_ODD(0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #(CLK_HALF) clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame; when expect_out is set the predicted result goes on the scoreboard first.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic bad_parity,
                                 input int bit_t, input logic expect_out);
        exp_t e;
        logic par_err;
        par_err = PARITY_ENABLED && bad_parity;
        if (expect_out) begin
            e.data = data;
            e.dv   = stop_bit && !par_err;
            e.fe   = !stop_bit;
            e.pe   = par_err;
            exp_q.push_back(e);
        end
        rxd = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            #(bit_t);
        end
        if (PARITY_ENABLED) begin
            rxd = (^data) ^ bad_parity;
            #(bit_t);
        end
        rxd = stop_bit;
        #(bit_t);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (data_valid || frame_err || parity_err) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", {29'd0, data_valid, frame_err, parity_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("data_out", {24'd0, data_out}, {24'd0, e.data});
                checkOutput("data_valid", {31'd0, data_valid}, {31'd0, e.dv});
                checkOutput("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
                checkOutput("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
            end
        end
    end

    initial begin
        #(20_000_000);
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset with the line held low: outputs cleared, no frame may start from the held-low line.
        rxd = 1'b0;
        #1 rst_n = 1'b0;
        waitCycles(3);
        checkOutput("reset_data_out", {24'd0, data_out}, 32'd0);
        checkOutput("reset_data_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("reset_parity_err", {31'd0, parity_err}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        waitCycles(30);
        checkOutput("held_low_no_start", {31'd0, busy}, 32'd0);
        rxd = 1'b1;
        waitCycles(30);

        $display("[TB] clean frame 0x55");
        applyStimulus(8'h55, 1'b1, 1'b0, BIT_T, 1'b1);
        waitCycles(40);
        checkOutput("clean_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("clean_all_seen", exp_q.size(), 32'd0);
        checkOutput("clean_hold", {24'd0, data_out}, 32'h55);

        $display("[TB] glitch of 4 ticks");
        rxd = 1'b0;
        #(4 * 2 * CLK_HALF);
        rxd = 1'b1;
        waitCycles(40);
        checkOutput("glitch_busy", {31'd0, busy}, 32'd0);
        checkOutput("glitch_hold", {24'd0, data_out}, 32'h55);

        $display("[TB] framing error 0xA3 then break");
        applyStimulus(8'hA3, 1'b0, 1'b0, BIT_T, 1'b1);
        #(3 * BIT_T);
        checkOutput("break_busy", {31'd0, busy}, 32'd1);
        checkOutput("break_one_pulse", exp_q.size(), 32'd0);
        rxd = 1'b1;
        waitCycles(40);
        checkOutput("break_release_busy", {31'd0, busy}, 32'd0);
        applyStimulus(8'h5A, 1'b1, 1'b0, BIT_T, 1'b1);
        waitCycles(40);
        checkOutput("recover_all_seen", exp_q.size(), 32'd0);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity frames 0x07");
        applyStimulus(8'h07, 1'b1, 1'b0, BIT_T, 1'b1);
        applyStimulus(8'h07, 1'b1, 1'b1, BIT_T, 1'b1);
        waitCycles(40);
        checkOutput("parity_all_seen", exp_q.size(), 32'd0);
        applyStimulus(8'hC1, 1'b0, 1'b1, BIT_T, 1'b1);
        rxd = 1'b1;
        waitCycles(40);
        checkOutput("double_err_seen", exp_q.size(), 32'd0);
`endif

        $display("[TB] reset during data bit 4 of 0xFF");
        @(negedge clk);
        fork
            applyStimulus(8'hFF, 1'b1, 1'b0, BIT_T, 1'b0);
            begin
                #(5 * BIT_T + 800);
                checkOutput("midframe_busy", {31'd0, busy}, 32'd1);
                rst_n = 1'b0;
                #10;
                checkOutput("async_data_out", {24'd0, data_out}, 32'd0);
                checkOutput("async_busy", {31'd0, busy}, 32'd0);
                checkOutput("async_flags", {29'd0, data_valid, frame_err, parity_err}, 32'd0);
                #220;
                rst_n = 1'b1;
            end
        join
        waitCycles(40);
        checkOutput("after_reset_busy", {31'd0, busy}, 32'd0);
        applyStimulus(8'h3C, 1'b1, 1'b0, BIT_T, 1'b1);
        waitCycles(40);
        checkOutput("after_reset_frame", exp_q.size(), 32'd0);
        checkOutput("after_reset_hold", {24'd0, data_out}, 32'h3C);

        $display("[TB] back-to-back with -3%% and +3%% bit period");
        applyStimulus(8'h00, 1'b1, 1'b0, BIT_FAST, 1'b1);
        applyStimulus(8'hFF, 1'b1, 1'b0, BIT_FAST, 1'b1);
        waitCycles(40);
        checkOutput("b2b_fast_seen", exp_q.size(), 32'd0);
        applyStimulus(8'h00, 1'b1, 1'b0, BIT_SLOW, 1'b1);
        applyStimulus(8'hFF, 1'b1, 1'b0, BIT_SLOW, 1'b1);
        waitCycles(40);
        checkOutput("b2b_slow_seen", exp_q.size(), 32'd0);
        checkOutput("b2b_final_data", {24'd0, data_out}, 32'hFF);
        checkOutput("b2b_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
